// File: rtl/mat_row_fetch_pkg.sv
// Shared definitions for mat_row_fetch: FSM state encoding, row geometry
// constants and the row-buffer byte selector.
// Latency: n/a (package). Backpressure: n/a.
package mat_row_fetch_pkg;

   localparam int BYTES_PER_ROW = 8;
   localparam int ROW_W         = 64;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      PUSH,
      DONE
   } state_t;

   // Byte k of a row, most significant byte first (k=0 -> bits 63:56).
   function automatic logic [7:0] byte_sel(input logic [ROW_W-1:0] row_buf,
                                           input logic [2:0]       idx);
      return row_buf[ROW_W-1 - 8*int'(idx) -: 8];
   endfunction

endpackage

// File: rtl/mat_row_fetch.sv
// Avalon-MM read master that fetches NUM_ROWS 64-bit matrix rows (one
// outstanding read at a time) and scatters each row, MSB byte first, into
// that row's byte FIFO.
// Latency: one read per row, plus 8 push cycles per row when no FIFO is full.
// Backpressure: honours avm_waitrequest (read/address held) and per-FIFO
// fifo_full (push stalls without loss).
// Ports: clk/reset (sync, active high); start/busy/done/error control;
// avm_* Avalon read master; fifo_wren (one-hot)/fifo_wdata/fifo_full to FIFOs.
module mat_row_fetch
   import mat_row_fetch_pkg::*;
#(
   parameter int          NUM_ROWS  = 8,
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int          TIMEOUT   = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [31:0]         avm_address,
   output logic                avm_read,
   input  logic [ROW_W-1:0]    avm_readdata,
   input  logic                avm_readdatavalid,
   input  logic                avm_waitrequest,
   output logic [NUM_ROWS-1:0] fifo_wren,
   output logic [7:0]          fifo_wdata,
   input  logic [NUM_ROWS-1:0] fifo_full
);

   localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
   localparam logic [2:0]    LAST_BYTE = 3'(BYTES_PER_ROW - 1);

   state_t           state, state_nxt;
   logic [RW-1:0]    row;
   logic [2:0]       byte_idx;
   logic [TW-1:0]    tcnt;
   logic [ROW_W-1:0] row_buf;
   logic             accept;
   logic             push_wr;

   assign accept = (state == REQ) && avm_read && !avm_waitrequest;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = (state != IDLE);
      done       = 1'b0;
      fifo_wren  = '0;
      fifo_wdata = 8'd0;
      push_wr    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = REQ;
         end
         REQ: begin
            if (accept) state_nxt = WAIT_DATA;
         end
         WAIT_DATA: begin
            // Data arriving on the last allowed cycle still wins over timeout.
            if (avm_readdatavalid)   state_nxt = PUSH;
            else if (tcnt == TO_LAST) state_nxt = DONE;
         end
         PUSH: begin
            fifo_wdata = byte_sel(row_buf, byte_idx);
            if (!fifo_full[row]) begin
               fifo_wren[row] = 1'b1;
               push_wr        = 1'b1;
               if (byte_idx == LAST_BYTE) begin
                  state_nxt = (row == LAST_ROW) ? DONE : REQ;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         error       <= 1'b0;
         row         <= '0;
         byte_idx    <= 3'd0;
         tcnt        <= '0;
         row_buf     <= '0;
         avm_read    <= 1'b0;
         avm_address <= 32'd0;
      end else begin
         if (state == IDLE && start) begin
            error       <= 1'b0;
            row         <= '0;
            avm_read    <= 1'b1;
            avm_address <= BASE_ADDR;
         end
         if (accept) begin
            avm_read <= 1'b0;
            tcnt     <= '0;
         end
         if (state == WAIT_DATA) begin
            if (avm_readdatavalid) begin
               row_buf  <= avm_readdata;
               byte_idx <= 3'd0;
            end else begin
               tcnt <= tcnt + TW'(1);
               if (tcnt == TO_LAST) error <= 1'b1;
            end
         end
         if (push_wr) begin
            byte_idx <= byte_idx + 3'd1;
            // Address is registered here so it is stable for the whole REQ.
            if (byte_idx == LAST_BYTE && row != LAST_ROW) begin
               row         <= row + RW'(1);
               avm_read    <= 1'b1;
               avm_address <= BASE_ADDR + 32'(row) + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mat_row_fetch.sv
// Self-checking bench for mat_row_fetch: behavioural Avalon slave with
// programmable latency/stall/drop, FIFO-full injection, and a scoreboard of
// expected per-FIFO byte streams derived from the row memory contents.
module tb_mat_row_fetch;

   localparam int          NUM_ROWS = 8;
   localparam logic [31:0] BASE     = 32'h0000_0100;
   localparam int          TIMEOUT  = 64;

   logic                clk;
   logic                reset;
   logic                start;
   logic                busy, done, error;
   logic [31:0]         avm_address;
   logic                avm_read;
   logic [63:0]         avm_readdata;
   logic                avm_readdatavalid;
   logic                avm_waitrequest;
   logic [NUM_ROWS-1:0] fifo_wren;
   logic [7:0]          fifo_wdata;
   logic [NUM_ROWS-1:0] fifo_full;

   mat_row_fetch #(.NUM_ROWS(NUM_ROWS), .BASE_ADDR(BASE), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .error(error), .avm_address(avm_address), .avm_read(avm_read),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
      .avm_waitrequest(avm_waitrequest), .fifo_wren(fifo_wren),
      .fifo_wdata(fifo_wdata), .fifo_full(fifo_full)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int lat;
      int stall_row; int stall_cyc;
      int full_row;  int full_byte; int full_cyc;
      int drop_row;
      bit rnd_data;  bit rnd_full;
      int repulse;
      bit exp_error; int exp_writes; int exp_accepts;
   } vec_t;

   int checks = 0;
   int failures = 0;

   // slave / stimulus knobs
   logic [63:0] mem [NUM_ROWS];
   int  k_lat, k_stall_row, k_stall_cyc, k_full_row, k_full_byte, k_drop_row;
   bit  k_rnd_full;
   int  full_left;
   bit  spur_now;
   // slave internal state
   bit  pend;
   int  lat_left, pend_row, req_cyc;
   // monitor state
   logic [7:0] got [NUM_ROWS][$];
   int  cyc, nwrites, accepts, dones, stall_cnt, full_hits, acc_cyc, err_cyc;
   logic [31:0] first_addr;
   bit  prev_stall, prev_err;
   logic [31:0] prev_addr;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: drive slave/FIFO inputs at negedge, sample DUT 1 unit later.
   task automatic tick();
      int r;
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      avm_readdata      = 64'd0;
      avm_waitrequest   = 1'b0;
      fifo_full         = '0;
      if (reset) begin
         pend    = 0;
         req_cyc = 0;
      end else begin
         if (spur_now) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 64'hDEAD_BEEF_0BAD_F00D;
            spur_now          = 0;
         end else if (pend) begin
            lat_left--;
            if (lat_left == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = mem[pend_row];
               pend              = 0;
            end
         end
         if (avm_read) begin
            r = int'(avm_address - BASE);
            if (r == k_stall_row && req_cyc < k_stall_cyc) begin
               avm_waitrequest = 1'b1;
               req_cyc++;
            end else begin
               req_cyc = 0;
               if (r != k_drop_row && r >= 0 && r < NUM_ROWS) begin
                  pend     = 1;
                  lat_left = k_lat;
                  pend_row = r;
               end
            end
         end
         if (k_full_row >= 0 && full_left > 0 && got[k_full_row].size() == k_full_byte) begin
            fifo_full[k_full_row] = 1'b1;
            full_left--;
         end
         if (k_rnd_full && $urandom_range(0, 2) == 0)
            fifo_full[$urandom_range(0, NUM_ROWS-1)] = 1'b1;
      end
      #1;
      cyc++;
      if (reset) begin
         prev_stall = 0;
         prev_err   = 0;
      end else begin
         if (fifo_wren != '0) begin
            checks++;
            if ($countones(fifo_wren) != 1 || (fifo_wren & fifo_full) != '0) begin
               failures++;
               $display("FAIL wren_onehot_notfull: wren=%b full=%b", fifo_wren, fifo_full);
            end
         end
         for (int i = 0; i < NUM_ROWS; i++) begin
            if (fifo_wren[i]) begin
               got[i].push_back(fifo_wdata);
               nwrites++;
            end
         end
         if (k_full_row >= 0 && fifo_full[k_full_row]) full_hits++;
         if (prev_stall) begin
            checks++;
            if (!avm_read || avm_address != prev_addr) begin
               failures++;
               $display("FAIL read_held_stable: read=%b addr=%0h expected read=1 addr=%0h",
                        avm_read, avm_address, prev_addr);
            end
         end
         if (avm_read && !avm_waitrequest) begin
            accepts++;
            if (accepts == 1) first_addr = avm_address;
            acc_cyc = cyc;
         end
         if (avm_read && avm_waitrequest) stall_cnt++;
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
         if (done) dones++;
         if (error && !prev_err) err_cyc = cyc;
         prev_err = error;
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < NUM_ROWS; i++) got[i].delete();
      nwrites = 0; accepts = 0; dones = 0; stall_cnt = 0; full_hits = 0;
      acc_cyc = -1; err_cyc = -1; first_addr = 32'hFFFF_FFFF;
   endtask

   function automatic vec_t mk(int lat, int srow, int scyc, int frow, int fbyte, int fcyc,
                               int drop, bit rdata, bit rfull, int rep);
      vec_t v;
      v.lat = lat; v.stall_row = srow; v.stall_cyc = scyc;
      v.full_row = frow; v.full_byte = fbyte; v.full_cyc = fcyc;
      v.drop_row = drop; v.rnd_data = rdata; v.rnd_full = rfull; v.repulse = rep;
      v.exp_error   = (drop >= 0);
      v.exp_writes  = (drop >= 0) ? 8 * drop : 8 * NUM_ROWS;
      v.exp_accepts = (drop >= 0) ? drop + 1 : NUM_ROWS;
      return v;
   endfunction

   task automatic load_mem(input bit rnd);
      for (int r = 0; r < NUM_ROWS; r++) begin
         if (rnd) mem[r] = {$urandom, $urandom};
         else begin
            mem[r] = 64'd0;
            for (int k = 0; k < 8; k++) mem[r] = (mem[r] << 8) | 64'(r * 16 + k);
         end
      end
   endtask

   task automatic set_knobs(input vec_t v);
      k_lat = v.lat; k_stall_row = v.stall_row; k_stall_cyc = v.stall_cyc;
      k_full_row = v.full_row; k_full_byte = v.full_byte; full_left = v.full_cyc;
      k_drop_row = v.drop_row; k_rnd_full = v.rnd_full;
   endtask

   task automatic check_rows(input string tag, input int drop);
      bit ok;
      int n;
      for (int r = 0; r < NUM_ROWS; r++) begin
         n  = (drop < 0 || r < drop) ? 8 : 0;
         ok = (got[r].size() == n);
         for (int k = 0; k < n && ok; k++)
            if (got[r][k] != 8'(mem[r] >> (56 - 8 * k))) ok = 0;
         checks++;
         if (!ok) begin
            failures++;
            $display("FAIL %s_fifo%0d: got %0d bytes, expected %0d bytes of %016h",
                     tag, r, got[r].size(), n, mem[r]);
         end
      end
   endtask

   task automatic run_fetch(input string tag, input vec_t v);
      int  n;
      bit  pulsed;
      set_knobs(v);
      load_mem(v.rnd_data);
      clear_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_busy_after_start"}, busy, 1'b1);
      check({tag, "_error_cleared"}, error, 1'b0);
      n = 0; pulsed = 0;
      while (dones == 0 && n < 5000) begin
         tick();
         n++;
         if (v.repulse >= 0 && !pulsed && nwrites >= v.repulse) begin
            start  = 1'b1;
            pulsed = 1;
         end else start = 1'b0;
      end
      start = 1'b0;
      check({tag, "_done_seen_in_budget"}, (dones > 0), 1'b1);
      repeat (4) tick();
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_error"}, error, v.exp_error);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_writes"}, nwrites, v.exp_writes);
      check({tag, "_accepts"}, accepts, v.exp_accepts);
      check({tag, "_first_addr"}, first_addr, BASE);
      if (v.stall_row >= 0) check({tag, "_stall_cycles"}, stall_cnt, v.stall_cyc);
      if (v.full_row >= 0) check({tag, "_full_cycles"}, full_hits, v.full_cyc);
      if (v.exp_error) check({tag, "_timeout_distance"}, err_cyc - acc_cyc, TIMEOUT + 1);
      check_rows(tag, v.drop_row);
   endtask

   vec_t vecs [8];

   initial begin
      int n;
      vecs[0] = mk(10, -1, 0, -1, 0, 0, -1, 0, 0, -1);  // 10-cycle slave, pattern rows
      vecs[1] = mk( 1,  2, 3, -1, 0, 0, -1, 0, 0, -1);  // waitrequest 3 cycles on row 2
      vecs[2] = mk( 3, -1, 0,  4, 3, 5, -1, 0, 0, -1);  // fifo 4 full at byte 3
      vecs[3] = mk(64, -1, 0, -1, 0, 0, -1, 1, 0, -1);  // data on the last allowed cycle
      vecs[4] = mk( 2, -1, 0, -1, 0, 0,  1, 0, 0, -1);  // row 1 never answers
      vecs[5] = mk( 4, -1, 0, -1, 0, 0, -1, 1, 0, 20);  // start re-pulsed mid-fetch
      vecs[6] = mk( 7, -1, 0, -1, 0, 0, -1, 1, 1, -1);  // random full flags
      vecs[7] = mk( 2,  0, 2,  7, 7, 3, -1, 1, 0, -1);  // stall row 0, full on last byte

      reset = 1'b1; start = 1'b0; spur_now = 0; cyc = 0;
      avm_readdata = 64'd0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
      fifo_full = '0;
      set_knobs(mk(1, -1, 0, -1, 0, 0, -1, 0, 0, -1));
      clear_stats();
      repeat (3) tick();
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_error", error, 1'b0);
      check("reset_read", avm_read, 1'b0);
      check("reset_addr", avm_address, 32'd0);
      check("reset_wren", fifo_wren, '0);
      check("reset_wdata", fifo_wdata, 8'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_fetch($sformatf("vec%0d", i), vecs[i]);
      for (int i = 0; i < 3; i++)
         run_fetch($sformatf("rnd%0d", i),
                   mk($urandom_range(1, 20), -1, 0, -1, 0, 0, -1, 1, 1, -1));

      // Spurious readdatavalid while idle must be ignored.
      clear_stats();
      spur_now = 1;
      repeat (6) tick();
      check("spur_no_writes", nwrites, 0);
      check("spur_busy", busy, 1'b0);
      check("spur_no_done", dones, 0);
      run_fetch("after_spur", mk(5, -1, 0, -1, 0, 0, -1, 1, 0, -1));

      // Reset while row 5 is being pushed, then a clean fetch from row 0.
      set_knobs(mk(3, -1, 0, -1, 0, 0, -1, 0, 0, -1));
      load_mem(1'b0);
      clear_stats();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (got[5].size() < 2 && n < 2000) begin
         tick();
         n++;
      end
      check("rst_reached_row5_push", (got[5].size() >= 2), 1'b1);
      reset = 1'b1;
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_read", avm_read, 1'b0);
      check("rst_addr", avm_address, 32'd0);
      check("rst_wren", fifo_wren, '0);
      check("rst_wdata", fifo_wdata, 8'd0);
      reset = 1'b0;
      tick();
      run_fetch("after_rst", mk(6, -1, 0, -1, 0, 0, -1, 1, 0, -1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mat_row_fetch.md
Name: mat_row_fetch

Overview:
- Avalon-MM read master (initiator) for the 8x8 matrix ROM slave.
- On a start pulse it reads NUM_ROWS 64-bit rows, one outstanding read at a time.
- Each row is split into 8 bytes and pushed into that row's byte FIFO, which feeds the MAC array.
- Sits between the matrix memory wrapper and the per-row input FIFOs.

Parameters:
- NUM_ROWS, 8, number of rows fetched per start; also the number of FIFOs.
- BASE_ADDR, 0, Avalon word address of row 0; row r is at BASE_ADDR+r.
- TIMEOUT, 64, maximum cycles to wait for readdatavalid after a read is accepted.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a fetch of all rows
- busy  output  1  high from the start accept until done
- done  output  1  one-cycle pulse when the fetch ends (success or error)
- error  output  1  sticky; set on timeout, cleared by the next accepted start or by reset
- avm_address  output  32  Avalon read address
- avm_read  output  1  Avalon read request
- avm_readdata  input  64  Avalon read data (one row)
- avm_readdatavalid  input  1  read data valid
- avm_waitrequest  input  1  slave stall
- fifo_wren  output  NUM_ROWS  one-hot write enable; bit r selects FIFO r
- fifo_wdata  output  8  byte shared by all FIFOs
- fifo_full  input  NUM_ROWS  per-FIFO full flags

Behaviour:
- Reset: every output is 0; state IDLE; row counter, byte counter and timeout counter are 0.
- Reset mid-operation aborts immediately. Any read already in flight is abandoned, and a late readdatavalid in IDLE is ignored.
- IDLE
  - busy=0.
  - On start: clear error, set row=0, go to REQ.
- REQ
  - avm_read=1 and avm_address=BASE_ADDR+row, both registered and held stable.
  - The read is accepted in the first cycle with avm_read=1 and avm_waitrequest=0.
  - On acceptance: avm_read drops to 0 the next cycle, timeout counter clears, go to WAIT_DATA.
  - While waitrequest=1, keep holding read and address.
- WAIT_DATA
  - On avm_readdatavalid: capture avm_readdata into the row buffer, set byte=0, go to PUSH.
  - The timeout counter increments each cycle. If it reaches TIMEOUT-1 without valid data: set error, go to DONE.
- PUSH
  - Byte k of the row is row_buf[63-8k -: 8], i.e. MSB byte first.
  - fifo_wren[row] = !fifo_full[row]. This is combinational from state, row and fifo_full; all other wren bits are 0.
  - fifo_wdata = current byte.
  - The byte counter advances only on cycles where wren is asserted. While full=1, stall with no write and no data loss.
  - After byte 7 is written:
    - if row==NUM_ROWS-1, go to DONE;
    - otherwise row+1 and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- busy is high in every state except IDLE.
- start is ignored while busy.
- avm_readdatavalid outside WAIT_DATA is ignored.
- Throughput: at most one outstanding read; never more than one wren bit high.
- The row counter is clog2(NUM_ROWS) bits wide.
- avm_address is zero-extended: BASE_ADDR plus the row counter, modulo 2^32.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, REQ, WAIT_DATA, PUSH, DONE);
  - the BYTES_PER_ROW=8 constant;
  - the ROW_W=64 constant.
- No sub-module is needed. The byte selector is a small function in the package.

Test Plan:
- Fetch with a slave that has a 10-cycle latency; row r = 64'h{r}0{r}1{r}2...{r}7:
  - FIFO r receives bytes r0,r1,...,r7 in that order;
  - done pulses once after 64 writes total;
  - error=0.
- Slave holds waitrequest=1 for 3 cycles on row 2 → avm_read and avm_address=BASE_ADDR+2 stay stable through all 3 cycles; exactly one read is accepted.
- fifo_full[4]=1 for 5 cycles during byte 3 of row 4 → no wren during the stall; bytes 3..7 then follow with no duplication or loss.
- Slave never returns valid on row 1 with TIMEOUT=64 → error=1 exactly 64 cycles after acceptance, done pulses, the next start clears error.
- start is re-pulsed mid-fetch, and a spurious readdatavalid arrives in IDLE → both are ignored; row counts are unchanged.
- reset is asserted during PUSH of row 5 → all outputs are 0 on the next cycle; a new start fetches from row 0.
